am_demod: RTL and testbench
===========================

AM_DEMOD -- requirements
Module: am_demod

Interface
REQ-001 The block SHALL have parameter INPUT_WIDTH, default 8, giving the width of the signed input sample.
REQ-002 The block SHALL have parameter OUTPUT_WIDTH, default 16, giving the width of the output envelope word; OUTPUT_WIDTH SHALL be greater than INPUT_WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in, input, INPUT_WIDTH bits: signed two's-complement RF/IF sample.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in is accepted on any rising edge where in_valid=1.
REQ-007 The block SHALL have port oversample_ratio, input, 8 bits: unsigned decimation factor N (samples per output).
REQ-008 The block SHALL have port out, output, OUTPUT_WIDTH bits: envelope estimate, signed two's-complement, always >= 0.
REQ-009 The block SHALL have port out_valid, output, 1 bit: one-cycle strobe marking a new out value.

Function
REQ-010 Each accepted sample SHALL be rectified to its magnitude |in|; -2^(INPUT_WIDTH-1) SHALL map to 2^(INPUT_WIDTH-1) with no wrap.
REQ-011 Magnitudes SHALL be summed in an accumulator at least INPUT_WIDTH+9 bits wide over a window of N accepted samples; the accumulator SHALL never overflow.
REQ-012 N SHALL be sampled from oversample_ratio on the first accepted sample of each window; changes mid-window SHALL take effect on the next window.
REQ-013 oversample_ratio=0 SHALL be treated as N=1.
REQ-014 Cycles with in_valid=0 SHALL neither advance the window count nor change the accumulator.
REQ-015 On completion of a window, the result SHALL be out = floor(sum * 2^(OUTPUT_WIDTH-INPUT_WIDTH) / N), i.e. the mean magnitude scaled to the output range.
REQ-016 If the REQ-015 result exceeds 2^(OUTPUT_WIDTH-1)-1, out SHALL saturate to 2^(OUTPUT_WIDTH-1)-1.
REQ-017 Latency: if the Nth sample of a window is accepted at edge k, out SHALL update and out_valid SHALL be 1 after edge k+1; out_valid SHALL be 0 after every other edge.
REQ-018 The divide SHALL be exact for every N in 1..255 and SHALL sustain one result per N input cycles down to N=1 (pipelined or combinational divider; no stall, no in_ready).
REQ-019 out SHALL hold its last value between out_valid strobes.
REQ-020 The next window SHALL start with the sample accepted after the Nth sample, with no lost or duplicated samples; the accumulator restarts from that sample's magnitude.

Reset
REQ-021 While reset=1 at a rising edge, the accumulator and window counter SHALL be cleared, out SHALL become 0 and out_valid SHALL become 0.
REQ-022 Inputs SHALL be ignored during reset.
REQ-023 A partial window in progress when reset asserts SHALL be discarded.
REQ-024 The first window after reset deasserts SHALL begin with the first accepted sample.

Verification
REQ-025 The bench SHALL apply in=64 constant, in_valid=1, N=8 -> out=16384 with out_valid pulsing exactly every 8 cycles, first pulse 1 cycle after the 8th sample.
REQ-026 The bench SHALL apply in alternating +100/-100, N=8 -> out=25600 every window.
REQ-027 The bench SHALL apply in=-128 constant, N=1 -> out saturates at 32767 with out_valid high every cycle.
REQ-028 The bench SHALL apply in=32, N=4 with in_valid toggled 1,0,1,0... -> out=8192, with out_valid once per 8 clocks.
REQ-029 The bench SHALL apply in=64, N=8, assert reset after 5 samples, release, then feed 8 samples of in=16 -> out=0 during reset, then out=4096 with no contamination from the discarded partial window.
REQ-030 The bench SHALL apply a 10.7 MHz carrier at 100 MS/s, amplitude-modulated by a 25 kHz tone (envelope (m/2+64)/128, carrier amplitude 127), with N=8 -> out tracks the 25 kHz envelope, in phase with the modulating tone, and remains within 0..32767.

Source files
------------

// File: rtl/am_demod.sv
// ---------------------------------------------------------------------------
// am_demod
//
// Purpose:
//   Envelope detector for a sampled AM signal. Every accepted sample is
//   rectified to its magnitude and summed over a window of N accepted
//   samples. At the end of each window the sum is scaled to the output range
//   and divided by N, which gives the mean magnitude. That result is
//   presented on out together with a one-cycle out_valid strobe.
//
// Ports:
//   clk              : single clock, all logic on the rising edge
//   reset            : synchronous, active-high; clears the window and the output
//   in               : signed two's-complement input sample (INPUT_WIDTH bits)
//   in_valid         : in is accepted on every rising edge where this is 1
//   oversample_ratio : decimation factor N, sampled on the first sample of a
//                      window (0 is treated as 1)
//   out              : envelope estimate, signed, never negative (OUTPUT_WIDTH bits)
//   out_valid        : one-cycle strobe marking a new out value
// ---------------------------------------------------------------------------
module am_demod #(
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [INPUT_WIDTH-1:0]  in,
  input  logic                    in_valid,
  input  logic [7:0]              oversample_ratio,
  output logic [OUTPUT_WIDTH-1:0] out,
  output logic                    out_valid
);

  // The accumulator has room for 255 full-scale magnitudes and spare headroom.
  // The division stage works on the sum after the scaling shift has been applied.
  localparam int ACC_W = INPUT_WIDTH + 9;
  localparam int SHIFT = OUTPUT_WIDTH - INPUT_WIDTH;
  localparam int DIV_W = ACC_W + SHIFT;
  localparam logic [DIV_W-1:0] MAX_OUT =
    DIV_W'((64'd1 << (OUTPUT_WIDTH - 1)) - 64'd1);

  // Stage 1 state: the window in progress
  logic [ACC_W-1:0]        r_acc;
  logic [7:0]              r_count;
  logic [7:0]              r_winN;

  // Stage 1 to stage 2 handoff: a finished window waiting for the divider
  logic [ACC_W-1:0]        r_sum;
  logic [7:0]              r_sumN;
  logic                    r_done;

  // Stage 2 output registers
  logic [OUTPUT_WIDTH-1:0] r_out;
  logic                    r_outValid;

  logic [INPUT_WIDTH-1:0]  w_mag;
  logic                    w_first;
  logic [7:0]              w_winN;
  logic [7:0]              w_countNext;
  logic                    w_last;
  logic [ACC_W-1:0]        w_sum;
  logic [DIV_W-1:0]        w_dividend;
  logic [DIV_W-1:0]        w_quot;
  logic [OUTPUT_WIDTH-1:0] w_outSat;

  // Rectifier. The magnitude is held as an unsigned value of the same width,
  // so the most negative input maps to 2^(INPUT_WIDTH-1) without wrapping.
  // A window count of zero means the next accepted sample opens a new window.
  // In that case N comes from the port, otherwise from the value latched for
  // the current window. The first sample restarts the sum from its own
  // magnitude, so the stale accumulator contents never leak into a new window.
  always_comb begin
    w_mag       = in[INPUT_WIDTH-1] ? (~in + INPUT_WIDTH'(1)) : in;
    w_first     = (r_count == 8'd0);
    if (w_first) begin
      w_winN = (oversample_ratio == 8'd0) ? 8'd1 : oversample_ratio;
    end else begin
      w_winN = r_winN;
    end
    w_countNext = r_count + 8'd1;
    w_last      = (w_countNext == w_winN);
    w_sum       = (w_first ? '0 : r_acc) + ACC_W'(w_mag);
  end

  // Scale, divide and saturate. The divider is purely combinational and sits
  // between two register stages. This keeps one result per cycle possible at
  // N=1 without stalling. r_sumN is never zero, so the division is always
  // defined.
  always_comb begin
    w_dividend = DIV_W'(r_sum) << SHIFT;
    w_quot     = w_dividend / {{(DIV_W - 8){1'b0}}, r_sumN};
    w_outSat   = (w_quot > MAX_OUT) ? MAX_OUT[OUTPUT_WIDTH-1:0]
                                    : w_quot[OUTPUT_WIDTH-1:0];
  end

  // Window accumulation. Only accepted samples move the count or the sum.
  // On the Nth sample the completed sum and its N are handed to the divider
  // stage, and the counter returns to zero so the next accepted sample opens
  // a fresh window. Reset discards any partial window and any finished window
  // that has not reached the output yet.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc   <= '0;
      r_count <= 8'd0;
      r_winN  <= 8'd1;
      r_sum   <= '0;
      r_sumN  <= 8'd1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (in_valid) begin
        if (w_last) begin
          r_count <= 8'd0;
          r_acc   <= '0;
          r_sum   <= w_sum;
          r_sumN  <= w_winN;
          r_done  <= 1'b1;
        end else begin
          r_count <= w_countNext;
          r_acc   <= w_sum;
          r_winN  <= w_winN;
        end
      end
    end
  end

  // Output stage. The result lands one edge after the window completes.
  // Between strobes the last value is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out      <= '0;
      r_outValid <= 1'b0;
    end else begin
      r_outValid <= r_done;
      if (r_done) begin
        r_out <= w_outSat;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_outValid;

endmodule

// File: tb/tb_am_demod.sv
// ---------------------------------------------------------------------------
// tb_am_demod
//
// Purpose:
//   Self-checking bench for am_demod. A reference model works on whole
//   windows: it keeps the magnitudes of the window in progress in a queue.
//   When the queue holds N entries it computes the scaled, saturated mean
//   with plain integer arithmetic. That result is expected on the cycle
//   after the window completes. The bench runs directed scenarios, then a
//   randomized run, then a modulated carrier.
//
// Ports: none (top-level bench)
// ---------------------------------------------------------------------------
module tb_am_demod;

  localparam int IW    = 8;
  localparam int OW    = 16;
  localparam longint SCALE  = longint'(1) << (OW - IW);
  localparam longint MAXOUT = (longint'(1) << (OW - 1)) - 1;

  logic          clk;
  logic          reset;
  logic [IW-1:0] dIn;
  logic          inValid;
  logic [7:0]    ratio;
  logic [OW-1:0] dOut;
  logic          outValid;

  int vectors;
  int miscompares;
  int pulseCount;

  // Reference model state
  longint winMag[$];
  int     winN;
  bit     pendValid;
  longint pendOut;
  longint expOut;
  bit     expValid;

  am_demod #(
    .INPUT_WIDTH (IW),
    .OUTPUT_WIDTH(OW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in              (dIn),
    .in_valid        (inValid),
    .oversample_ratio(ratio),
    .out             (dOut),
    .out_valid       (outValid)
  );

  // Free-running 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Every comparison goes through here; a mismatch prints a FAIL line
  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    vectors++;
    if (observed != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drives one clock cycle of inputs, advances the reference model through
  // the same edge, and checks out / out_valid just after the edge
  task automatic applyStimulus(input logic [IW-1:0] sample, input logic valid,
                               input logic [7:0] n, input logic rst);
    longint mag;
    longint sum;
    longint q;
    @(negedge clk);
    dIn     = sample;
    inValid = valid;
    ratio   = n;
    reset   = rst;
    @(posedge clk);
    #1;
    if (rst) begin
      winMag.delete();
      pendValid = 0;
      expValid  = 0;
      expOut    = 0;
    end else begin
      expValid = pendValid;
      if (pendValid) expOut = pendOut;
      pendValid = 0;
      if (valid) begin
        if (winMag.size() == 0) winN = (n == 8'd0) ? 1 : int'(n);
        mag = longint'($signed(sample));
        if (mag < 0) mag = -mag;
        winMag.push_back(mag);
        if (winMag.size() == winN) begin
          sum = 0;
          foreach (winMag[i]) sum += winMag[i];
          q = (sum * SCALE) / winN;
          pendOut   = (q > MAXOUT) ? MAXOUT : q;
          pendValid = 1;
          winMag.delete();
        end
      end
    end
    if (outValid === 1'b1) pulseCount++;
    checkOutput("out_valid", longint'(outValid), longint'(expValid));
    checkOutput("out", longint'(dOut), expOut);
  endtask

  task automatic doReset(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus('0, 1'b0, 8'd0, 1'b1);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus('0, 1'b0, 8'd8, 1'b0);
  endtask

  initial begin
    int    amOutPeak;
    int    amOutTrough;
    int    amRangeErr;
    real   t;
    real   m;
    real   env;
    int    v;
    logic [IW-1:0] s;

    vectors     = 0;
    miscompares = 0;
    pulseCount  = 0;
    winN        = 1;
    pendValid   = 0;
    pendOut     = 0;
    expOut      = 0;
    expValid    = 0;
    dIn         = '0;
    inValid     = 1'b0;
    ratio       = 8'd8;
    reset       = 1'b1;

    // Reset state, with garbage on the inputs that must be ignored
    for (int i = 0; i < 3; i++) applyStimulus(8'h7f, 1'b1, 8'd1, 1'b1);
    checkOutput("resetOut", longint'(dOut), 0);
    checkOutput("resetValid", longint'(outValid), 0);

    // Constant 64, N=8: mean 64 scaled by 256
    pulseCount = 0;
    for (int i = 0; i < 40; i++) applyStimulus(8'd64, 1'b1, 8'd8, 1'b0);
    idle(2);
    checkOutput("const64Pulses", pulseCount, 5);
    checkOutput("const64Out", longint'(dOut), 16384);

    // Alternating +100/-100, N=8
    doReset(1);
    pulseCount = 0;
    for (int i = 0; i < 32; i++)
      applyStimulus((i % 2 == 0) ? 8'd100 : 8'(-100), 1'b1, 8'd8, 1'b0);
    idle(2);
    checkOutput("alt100Pulses", pulseCount, 4);
    checkOutput("alt100Out", longint'(dOut), 25600);

    // -128 with N=1 saturates every cycle
    doReset(1);
    pulseCount = 0;
    for (int i = 0; i < 10; i++) applyStimulus(8'h80, 1'b1, 8'd1, 1'b0);
    idle(1);
    checkOutput("satPulses", pulseCount, 10);
    checkOutput("satOut", longint'(dOut), 32767);

    // ratio 0 behaves like N=1
    doReset(1);
    pulseCount = 0;
    for (int i = 0; i < 4; i++) applyStimulus(8'd3, 1'b1, 8'd0, 1'b0);
    idle(1);
    checkOutput("ratio0Pulses", pulseCount, 4);
    checkOutput("ratio0Out", longint'(dOut), 768);

    // 32 with N=4 and in_valid toggling
    doReset(1);
    pulseCount = 0;
    for (int i = 0; i < 32; i++) applyStimulus(8'd32, (i % 2 == 0), 8'd4, 1'b0);
    idle(2);
    checkOutput("gapPulses", pulseCount, 4);
    checkOutput("gapOut", longint'(dOut), 8192);

    // Partial window discarded by reset
    doReset(1);
    for (int i = 0; i < 5; i++) applyStimulus(8'd64, 1'b1, 8'd8, 1'b0);
    doReset(2);
    checkOutput("midResetOut", longint'(dOut), 0);
    pulseCount = 0;
    for (int i = 0; i < 8; i++) applyStimulus(8'd16, 1'b1, 8'd8, 1'b0);
    idle(2);
    checkOutput("postResetPulses", pulseCount, 1);
    checkOutput("postResetOut", longint'(dOut), 4096);

    // Randomized: random samples, gaps, ratios that change mid-window, rare resets
    doReset(1);
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] rn;
      rn = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(100, 255))
                                         : 8'($urandom_range(0, 12));
      applyStimulus(IW'($urandom), ($urandom_range(0, 3) != 0), rn,
                    ($urandom_range(0, 299) == 0));
    end
    idle(2);

    // 10.7 MHz carrier at 100 MS/s, AM by 25 kHz, N=8: one full tone period
    doReset(1);
    amOutPeak   = 0;
    amOutTrough = 0;
    amRangeErr  = 0;
    for (int n = 0; n < 4000; n++) begin
      t   = n / 100.0e6;
      m   = 127.0 * $sin(2.0 * 3.14159265358979 * 25.0e3 * t);
      env = (m / 2.0 + 64.0) / 128.0;
      v   = int'(127.0 * env * $cos(2.0 * 3.14159265358979 * 10.7e6 * t));
      s   = IW'(v);
      applyStimulus(s, 1'b1, 8'd8, 1'b0);
      if ($signed(dOut) < 0) amRangeErr++;
      if (n == 1010) amOutPeak = int'(dOut);
      if (n == 3010) amOutTrough = int'(dOut);
    end
    checkOutput("amRange", amRangeErr, 0);
    checkOutput("amPhase", longint'(amOutPeak > amOutTrough + 8000), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
